// File: rtl/adsr_env_ctrl.sv
// ADSR envelope controller for a PWM voice: programmable step divider, envelope
// sub-divider, and a gate-driven attack/decay/sustain/release level sequencer.
module adsr_env_ctrl #(
  parameter int N     = 8,
  parameter int DIV_W = 16,
  parameter int ENV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             gate,
  input  logic [DIV_W-1:0] tick_div,
  input  logic [N-1:0]     attack_rate,
  input  logic [N-1:0]     decay_rate,
  input  logic [N-1:0]     sustain_level,
  input  logic [N-1:0]     release_rate,
  output logic             pwm_step,
  output logic             pwm_ena,
  output logic [N-1:0]     duty,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           r_state, w_next_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pwm_step, r_pwm_ena;
  logic [N-1:0]     r_duty, w_next_duty;
  logic             w_wrap, w_env_tick;
  logic [N:0]       w_att_sum, w_dec_diff, w_rel_diff;

  // >= rather than == so a tick_div lowered below the count wraps immediately
  assign w_wrap = ena && (r_div_cnt >= tick_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_pwm_step <= 1'b0;
    end else if (ena) begin
      if (w_wrap) begin
        r_div_cnt  <= '0;
        r_pwm_step <= 1'b1;
      end else begin
        r_div_cnt  <= r_div_cnt + DIV_W'(1);
        r_pwm_step <= 1'b0;
      end
    end else begin
      r_pwm_step <= 1'b0;
    end
  end

  generate
    if (ENV_W == 0) begin : g_no_env
      assign w_env_tick = w_wrap;
    end else begin : g_env
      logic [ENV_W-1:0] r_env_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_env_cnt <= '0;
        else if (w_wrap) r_env_cnt <= r_env_cnt + ENV_W'(1);
      end
      assign w_env_tick = w_wrap && (r_env_cnt == '1);
    end
  endgenerate

  assign w_att_sum  = {1'b0, r_duty} + {1'b0, attack_rate};
  assign w_dec_diff = {1'b0, r_duty} - {1'b0, decay_rate};
  assign w_rel_diff = {1'b0, r_duty} - {1'b0, release_rate};

  always_comb begin
    w_next_state = r_state;
    w_next_duty  = r_duty;
    case (r_state)
      S_IDLE: begin
        if (gate) w_next_state = S_ATTACK;
        else      w_next_duty  = '0;
      end
      S_ATTACK: begin
        if (!gate) begin
          w_next_state = S_RELEASE;
        end else if (w_env_tick) begin
          if (attack_rate == '0 || w_att_sum[N] || w_att_sum[N-1:0] == '1) begin
            w_next_duty  = '1;
            w_next_state = S_DECAY;
          end else begin
            w_next_duty = w_att_sum[N-1:0];
          end
        end
      end
      S_DECAY: begin
        if (!gate) begin
          w_next_state = S_RELEASE;
        end else if (w_env_tick) begin
          if (decay_rate == '0 || w_dec_diff[N] || w_dec_diff[N-1:0] <= sustain_level) begin
            w_next_duty  = sustain_level;
            w_next_state = S_SUSTAIN;
          end else begin
            w_next_duty = w_dec_diff[N-1:0];
          end
        end
      end
      S_SUSTAIN: begin
        if (!gate)    w_next_state = S_RELEASE;
        else if (ena) w_next_duty  = sustain_level;
      end
      S_RELEASE: begin
        if (gate) begin
          w_next_state = S_ATTACK;
        end else if (w_env_tick) begin
          if (release_rate == '0 || w_rel_diff[N] || w_rel_diff == '0) begin
            w_next_duty  = '0;
            w_next_state = S_IDLE;
          end else begin
            w_next_duty = w_rel_diff[N-1:0];
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_duty  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_duty    <= '0;
      r_pwm_ena <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_duty    <= w_next_duty;
      r_pwm_ena <= (w_next_state != S_IDLE);
    end
  end

  assign pwm_step = r_pwm_step;
  assign pwm_ena  = r_pwm_ena;
  assign duty     = r_duty;
  assign state    = r_state;

  a_state_range: assert property (@(posedge clk) disable iff (!rst) r_state <= S_RELEASE);
  a_idle_zero: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_IDLE) |-> (r_duty == '0));
  a_attack_no_wrap: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_ATTACK && $past(r_state) == S_ATTACK) |-> (r_duty >= $past(r_duty)));
  a_release_no_wrap: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_RELEASE && $past(r_state) == S_RELEASE) |-> (r_duty <= $past(r_duty)));

endmodule

// File: tb/tb_adsr_env_ctrl.sv
// Bench for adsr_env_ctrl: directed envelope table, hand sequences for corner
// cases, and randomized stimulus against an arithmetic reference model.
module tb_adsr_env_ctrl;

  localparam int MAXL = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] tick_div = '0;
  logic [7:0]  attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;

  logic       step0, pena0, step1, pena1;
  logic [7:0] duty0, duty1;
  logic [2:0] st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adsr_env_ctrl #(.N(8), .DIV_W(16), .ENV_W(0)) u_dut0 (
    .clk(clk), .rst(rst), .ena(ena), .gate(gate), .tick_div(tick_div),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .pwm_step(step0), .pwm_ena(pena0), .duty(duty0), .state(st0)
  );

  adsr_env_ctrl #(.N(8), .DIV_W(16), .ENV_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena), .gate(gate), .tick_div(tick_div),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .pwm_step(step1), .pwm_ena(pena1), .duty(duty1), .state(st1)
  );

  // Reference model: index 0 mirrors ENV_W=0 (tick every wrap), index 1 ENV_W=2.
  int m_div[2], m_env[2], m_duty[2], m_st[2], m_step[2], m_pena[2];
  int env_period[2] = '{1, 4};

  task automatic model_clk(int k);
    bit wrap;
    bit tick;
    int v;
    wrap = 1'b0;
    tick = 1'b0;
    if (ena) begin
      wrap = (m_div[k] >= int'(tick_div));
      m_div[k] = wrap ? 0 : m_div[k] + 1;
    end
    m_step[k] = wrap ? 1 : 0;
    if (wrap) begin
      tick = (m_env[k] == env_period[k] - 1);
      m_env[k] = (m_env[k] + 1) % env_period[k];
    end
    case (m_st[k])
      0: if (gate) m_st[k] = 1; else m_duty[k] = 0;
      1: if (!gate) m_st[k] = 4;
         else if (tick) begin
           v = m_duty[k] + int'(attack_rate);
           if (attack_rate == 0 || v > MAXL) v = MAXL;
           m_duty[k] = v;
           if (v == MAXL) m_st[k] = 2;
         end
      2: if (!gate) m_st[k] = 4;
         else if (tick) begin
           v = m_duty[k] - int'(decay_rate);
           if (decay_rate == 0 || v < int'(sustain_level)) v = int'(sustain_level);
           m_duty[k] = v;
           if (v == int'(sustain_level)) m_st[k] = 3;
         end
      3: if (!gate) m_st[k] = 4; else if (ena) m_duty[k] = int'(sustain_level);
      default: if (gate) m_st[k] = 1;
         else if (tick) begin
           v = m_duty[k] - int'(release_rate);
           if (release_rate == 0 || v < 0) v = 0;
           m_duty[k] = v;
           if (v == 0) m_st[k] = 0;
         end
    endcase
    m_pena[k] = (m_st[k] != 0) ? 1 : 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_div[k] = 0; m_env[k] = 0; m_duty[k] = 0;
        m_st[k] = 0; m_step[k] = 0; m_pena[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_clk(k);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk0_now(input string tag, input int d, input int s, input int p, input int stp);
    check({tag, ".duty"}, 32'(duty0), d);
    check({tag, ".state"}, 32'(st0), s);
    check({tag, ".pwm_ena"}, 32'(pena0), p);
    check({tag, ".pwm_step"}, 32'(step0), stp);
  endtask

  task automatic chk0(input string tag, input int d, input int s, input int p);
    @(posedge clk); #1;
    chk0_now(tag, d, s, p, 1);
  endtask

  // Called 1 time unit after a rising edge; pulse ends well before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  task automatic set_rates(input int a, input int d, input int s, input int r);
    attack_rate = 8'(a); decay_rate = 8'(d); sustain_level = 8'(s); release_rate = 8'(r);
  endtask

  function automatic logic [7:0] rnd_rate();
    return ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endfunction

  typedef struct {
    logic gate;
    int   exp_duty;
    int   exp_state;
    int   exp_pena;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl = '{
      '{1'b1,   0, 1, 1}, '{1'b1,  64, 1, 1}, '{1'b1, 128, 1, 1}, '{1'b1, 192, 1, 1},
      '{1'b1, 255, 2, 1}, '{1'b1, 223, 2, 1}, '{1'b1, 191, 2, 1}, '{1'b1, 159, 2, 1},
      '{1'b1, 128, 3, 1}, '{1'b1, 128, 3, 1}, '{1'b0, 128, 4, 1}, '{1'b0, 112, 4, 1},
      '{1'b0,  96, 4, 1}, '{1'b0,  80, 4, 1}, '{1'b0,  64, 4, 1}, '{1'b0,  48, 4, 1},
      '{1'b0,  32, 4, 1}, '{1'b0,  16, 4, 1}, '{1'b0,   0, 0, 0}, '{1'b0,   0, 0, 0}
    };

    #1 rst = 1'b0;
    #2 chk0_now("reset_init", 0, 0, 0, 0);
    @(posedge clk); #1;

    // Step divider: pulses every 4th edge, shifted by an ena gap, then a live tick_div drop.
    tick_div = 16'd3; ena = 1'b1; gate = 1'b0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("div.step%0d", c), 32'(step0), (c % 4 == 0) ? 1 : 0);
    end
    ena = 1'b0;
    for (int c = 13; c <= 17; c++) begin
      @(posedge clk); #1;
      check($sformatf("div.hold%0d", c), 32'(step0), 0);
    end
    ena = 1'b1;
    for (int c = 18; c <= 24; c++) begin
      @(posedge clk); #1;
      check($sformatf("div.shift%0d", c), 32'(step0), (c == 21) ? 1 : 0);
    end
    tick_div = 16'd10;
    for (int c = 25; c <= 26; c++) begin
      @(posedge clk); #1;
      check($sformatf("div.long%0d", c), 32'(step0), 0);
    end
    tick_div = 16'd2;
    @(posedge clk); #1;
    check("div.shrink_wrap", 32'(step0), 1);
    check("div.idle_duty", 32'(duty0), 0);

    // Full envelope from table.
    tick_div = '0; ena = 1'b1; gate = 1'b0;
    set_rates(64, 32, 128, 16);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      gate = tbl[i].gate;
      chk0($sformatf("env[%0d]", i), tbl[i].exp_duty, tbl[i].exp_state, tbl[i].exp_pena);
    end

    // Retrigger from RELEASE keeps the level.
    set_rates(100, 32, 128, 32); gate = 1'b1;
    do_reset();
    chk0("retrig.a0", 0, 1, 1);
    chk0("retrig.a1", 100, 1, 1);
    chk0("retrig.a2", 200, 1, 1);
    gate = 1'b0;
    chk0("retrig.rel0", 200, 4, 1);
    chk0("retrig.rel1", 168, 4, 1);
    gate = 1'b1; attack_rate = 8'd64;
    chk0("retrig.att0", 168, 1, 1);
    chk0("retrig.att1", 232, 1, 1);
    chk0("retrig.att2", 255, 2, 1);

    // Zero rates are instantaneous.
    set_rates(0, 0, 100, 0); gate = 1'b1;
    do_reset();
    chk0("zero.t0", 0, 1, 1);
    chk0("zero.t1", 255, 2, 1);
    chk0("zero.t2", 100, 3, 1);
    gate = 1'b0;
    chk0("zero.t3", 100, 4, 1);
    chk0("zero.t4", 0, 0, 0);

    // Gate drop colliding with an envelope tick in DECAY.
    set_rates(0, 10, 100, 16); gate = 1'b1;
    do_reset();
    chk0("coll.t0", 0, 1, 1);
    chk0("coll.t1", 255, 2, 1);
    chk0("coll.t2", 245, 2, 1);
    gate = 1'b0;
    chk0("coll.t3", 245, 4, 1);
    chk0("coll.t4", 229, 4, 1);

    // Live sustain change.
    set_rates(0, 0, 128, 16); gate = 1'b1;
    do_reset();
    chk0("sus.t0", 0, 1, 1);
    chk0("sus.t1", 255, 2, 1);
    chk0("sus.t2", 128, 3, 1);
    sustain_level = 8'd90;
    chk0("sus.t3", 90, 3, 1);

    // Asynchronous reset mid-ATTACK.
    set_rates(64, 32, 128, 16); gate = 1'b1;
    do_reset();
    chk0("rstm.t0", 0, 1, 1);
    chk0("rstm.t1", 64, 1, 1);
    chk0("rstm.t2", 128, 1, 1);
    #1 rst = 1'b0;
    #1 chk0_now("rstm.async", 0, 0, 0, 0);
    #1 rst = 1'b1;
    chk0("rstm.t3", 0, 1, 1);
    chk0("rstm.t4", 64, 1, 1);

    // Randomized run against the reference model, both sub-divider widths.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        attack_rate = rnd_rate(); decay_rate = rnd_rate(); release_rate = rnd_rate();
        sustain_level = 8'($urandom_range(0, 255));
        tick_div = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(posedge clk); #1;
      check("rnd0.duty", 32'(duty0), m_duty[0]);
      check("rnd0.state", 32'(st0), m_st[0]);
      check("rnd0.step", 32'(step0), m_step[0]);
      check("rnd0.pena", 32'(pena0), m_pena[0]);
      check("rnd1.duty", 32'(duty1), m_duty[1]);
      check("rnd1.state", 32'(st1), m_st[1]);
      check("rnd1.step", 32'(step1), m_step[1]);
      check("rnd1.pena", 32'(pena1), m_pena[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
